// File: rtl/approx_mul_arbiter.sv
// Round-robin share of one external combinational 8x8 approximate multiplier among NREQ requesters.
// Latency: accept at edge k, operands on mul_x/mul_y after k, tagged response after k+1.
// Backpressure: a stalled response holds stage 1 full, which drops every req_ready.
module approx_mul_arbiter #(
  parameter int NREQ = 4,
  parameter int W    = 8,
  parameter int IDW  = 2
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [NREQ-1:0]   req_valid,
  input  logic [NREQ*W-1:0] req_x,
  input  logic [NREQ*W-1:0] req_y,
  output logic [NREQ-1:0]   req_ready,
  output logic [W-1:0]      mul_x,
  output logic [W-1:0]      mul_y,
  input  logic [2*W-1:0]    mul_z,
  output logic              rsp_valid,
  output logic [IDW-1:0]    rsp_id,
  output logic [2*W-1:0]    rsp_z,
  input  logic              rsp_ready,
  output logic [15:0]       op_cnt
);

  logic            s1_valid;
  logic [IDW-1:0]  s1_id;
  logic [IDW-1:0]  rr_ptr;
  logic            adv1;
  logic            adv2;
  logic            any_req;
  logic [IDW-1:0]  gnt_idx;
  logic [NREQ-1:0] grant;
  logic [IDW-1:0]  next_ptr;
  logic            accept;
  logic            rsp_hs;

  assign adv2   = s1_valid & (~rsp_valid | rsp_ready);
  assign adv1   = ~s1_valid | adv2;
  assign rsp_hs = rsp_valid & rsp_ready;

  // Search starts at rr_ptr and wraps, so the last-served requester goes to the back.
  always_comb begin
    int idx;
    any_req = 1'b0;
    gnt_idx = '0;
    grant   = '0;
    idx     = 0;
    for (int k = 0; k < NREQ; k++) begin
      idx = int'(rr_ptr) + k;
      if (idx >= NREQ) idx = idx - NREQ;
      if (!any_req && req_valid[IDW'(idx)]) begin
        any_req = 1'b1;
        gnt_idx = IDW'(idx);
      end
    end
    if (any_req) grant = NREQ'(1) << gnt_idx;
  end

  assign next_ptr  = (gnt_idx == IDW'(NREQ - 1)) ? '0 : gnt_idx + 1'b1;
  assign accept    = adv1 & any_req;
  assign req_ready = grant & {NREQ{adv1 & rst_n}};

  // Operand registers only load on accept so the multiplier inputs stay quiet when idle.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_valid <= 1'b0;
      s1_id    <= '0;
      mul_x    <= '0;
      mul_y    <= '0;
      rr_ptr   <= '0;
    end else if (adv1) begin
      s1_valid <= any_req;
      if (any_req) begin
        mul_x  <= req_x[gnt_idx*W +: W];
        mul_y  <= req_y[gnt_idx*W +: W];
        s1_id  <= gnt_idx;
        rr_ptr <= next_ptr;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rsp_valid <= 1'b0;
      rsp_id    <= '0;
      rsp_z     <= '0;
    end else if (adv2) begin
      rsp_valid <= 1'b1;
      rsp_id    <= s1_id;
      rsp_z     <= mul_z;
    end else if (rsp_hs) begin
      rsp_valid <= 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) op_cnt <= '0;
    else if (rsp_hs) op_cnt <= op_cnt + 16'd1;
  end

  logic unused_accept;
  assign unused_accept = accept;

endmodule

// File: tb/tb_approx_mul_arbiter.sv
// Directed bench for approx_mul_arbiter with an exact-product multiplier stub.
// Stimulus pushes hand-computed (id, product) pairs; a negedge monitor pops them on each response handshake.
module tb_approx_mul_arbiter;
  localparam int NREQ = 4;
  localparam int W    = 8;
  localparam int IDW  = 2;

  logic              clk = 1'b0;
  logic              rst_n;
  logic [NREQ-1:0]   req_valid;
  logic [NREQ*W-1:0] req_x;
  logic [NREQ*W-1:0] req_y;
  logic [NREQ-1:0]   req_ready;
  logic [W-1:0]      mul_x;
  logic [W-1:0]      mul_y;
  logic [2*W-1:0]    mul_z;
  logic              rsp_valid;
  logic [IDW-1:0]    rsp_id;
  logic [2*W-1:0]    rsp_z;
  logic              rsp_ready;
  logic [15:0]       op_cnt;

  approx_mul_arbiter #(.NREQ(NREQ), .W(W), .IDW(IDW)) dut (
    .clk(clk), .rst_n(rst_n),
    .req_valid(req_valid), .req_x(req_x), .req_y(req_y), .req_ready(req_ready),
    .mul_x(mul_x), .mul_y(mul_y), .mul_z(mul_z),
    .rsp_valid(rsp_valid), .rsp_id(rsp_id), .rsp_z(rsp_z), .rsp_ready(rsp_ready),
    .op_cnt(op_cnt)
  );

  assign mul_z = 16'(mul_x) * 16'(mul_y);

  always #5 clk = ~clk;

  typedef struct {
    logic [IDW-1:0] id;
    logic [2*W-1:0] z;
  } exp_t;

  exp_t sb_q[$];
  int   n_cmp = 0;
  int   n_bad = 0;
  logic sb_bypass = 1'b0;

  always @(negedge clk) begin
    if (rst_n && rsp_valid && rsp_ready && !sb_bypass) begin
      n_cmp++;
      if (sb_q.size() == 0) begin
        n_bad++;
        $display("FAIL rsp_unexpected: got id=%0d z=%0d, required no response", rsp_id, rsp_z);
      end else begin
        exp_t e;
        e = sb_q.pop_front();
        if (rsp_id !== e.id || rsp_z !== e.z) begin
          n_bad++;
          $display("FAIL rsp_data: got id=%0d z=%0d, required id=%0d z=%0d", rsp_id, rsp_z, e.id, e.z);
        end
      end
    end
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    n_cmp++;
    if (act !== req) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h, required 0x%0h", name, act, req);
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic smp();
    @(negedge clk);
  endtask

  task automatic push(input int id, input int z);
    exp_t e;
    e.id = IDW'(id);
    e.z  = 16'(z);
    sb_q.push_back(e);
  endtask

  task automatic set_op(input int i, input int x, input int y);
    req_x[i*W +: W] = W'(x);
    req_y[i*W +: W] = W'(y);
  endtask

  task automatic drain(input string name);
    for (int i = 0; i < 20 && sb_q.size() != 0; i++) cyc();
    chk(name, 32'(sb_q.size()), 32'd0);
  endtask

  initial begin
    int exp_id [6];
    int prod   [4];
    int acc;
    int hs;
    int n_acc;
    bit seen_ffff;

    exp_id = '{0, 1, 2, 3, 0, 1};
    prod   = '{6, 20, 42, 50000};

    // Reset state, with all requests raised to exercise the reset gating of req_ready.
    rst_n = 1'b0; req_valid = '1; req_x = '0; req_y = '0; rsp_ready = 1'b1;
    smp();
    chk("rst_req_ready", 32'(req_ready), 32'd0);
    chk("rst_rsp_valid", 32'(rsp_valid), 32'd0);
    chk("rst_mul_x",     32'(mul_x),     32'd0);
    chk("rst_rsp_z",     32'(rsp_z),     32'd0);
    chk("rst_op_cnt",    32'(op_cnt),    32'd0);
    cyc();
    req_valid = '0; rst_n = 1'b1;
    cyc();

    // Single op: 12 * 10 from requester 0.
    set_op(0, 12, 10); req_valid = 4'b0001;
    smp(); chk("single_gnt", 32'(req_ready), 32'b0001);
    push(0, 120);
    cyc(); req_valid = '0;
    smp(); chk("single_mul_x", 32'(mul_x), 32'd12);
    chk("single_lat1", 32'(rsp_valid), 32'd0);
    cyc();
    smp(); chk("single_lat2", 32'(rsp_valid), 32'd1);
    cyc();
    smp(); chk("single_op_cnt", 32'(op_cnt), 32'd1);
    chk("single_done", 32'(rsp_valid), 32'd0);

    // Skip and pointer: grant 1, idle, then 1010 must go to 3 before 1.
    set_op(1, 3, 7); set_op(3, 9, 11);
    cyc(); req_valid = 4'b0010;
    smp(); chk("skip_g1", 32'(req_ready), 32'b0010);
    push(1, 21);
    cyc(); req_valid = '0;
    repeat (3) cyc();
    smp(); chk("idle_mul_x_hold", 32'(mul_x), 32'd3);
    cyc(); req_valid = 4'b1010;
    smp(); chk("skip_g3", 32'(req_ready), 32'b1000);
    push(3, 99);
    cyc();
    smp(); chk("skip_g1b", 32'(req_ready), 32'b0010);
    push(1, 21);
    cyc(); req_valid = '0;
    drain("skip_drain");

    // Fill both stages, then reset mid-flight.
    set_op(0, 7, 8); rsp_ready = 1'b0; req_valid = 4'b0001;
    cyc(); cyc();
    smp(); chk("full_stall_rdy", 32'(req_ready), 32'd0);
    chk("full_rsp_valid", 32'(rsp_valid), 32'd1);
    cyc();
    rst_n = 1'b0;
    #2;
    chk("async_rsp_valid", 32'(rsp_valid), 32'd0);
    chk("async_mul_x",     32'(mul_x),     32'd0);
    chk("async_op_cnt",    32'(op_cnt),    32'd0);
    chk("async_req_ready", 32'(req_ready), 32'd0);
    sb_q.delete();
    cyc();

    // Round robin with all four requesters held high; first grant must go to 0.
    set_op(0, 2, 3); set_op(1, 4, 5); set_op(2, 6, 7); set_op(3, 200, 250);
    req_valid = 4'b1111; rsp_ready = 1'b1; rst_n = 1'b1;
    smp(); chk("rr_no_stale", 32'(rsp_valid), 32'd0);
    for (int j = 0; j < 6; j++) begin
      if (j > 0) smp();
      chk("rr_gnt", 32'(req_ready), 32'(1) << exp_id[j]);
      if (j >= 2) chk("rr_tput", 32'(rsp_valid), 32'd1);
      push(exp_id[j], prod[exp_id[j]]);
      cyc();
    end
    req_valid = '0;
    drain("rr_drain");

    // Backpressure from requester 2 while rsp_ready is low for four cycles.
    set_op(2, 3, 5); rsp_ready = 1'b0; req_valid = 4'b0100;
    n_acc = 0;
    for (int c = 0; c < 4; c++) begin
      smp();
      if (req_ready[2]) begin
        n_acc++;
        if (n_acc == 1) push(2, 15);
        if (n_acc == 2) push(2, 20);
      end
      if (c >= 2) chk("bp_rsp_z_hold", 32'(rsp_z), 32'd15);
      cyc();
      if (n_acc == 1) set_op(2, 4, 5);
      if (n_acc == 2) set_op(2, 5, 5);
    end
    chk("bp_accepts", 32'(n_acc), 32'd2);
    smp(); chk("bp_rdy_low", 32'(req_ready), 32'd0);
    cyc(); rsp_ready = 1'b1;
    smp(); chk("bp_resume", 32'(req_ready), 32'b0100);
    push(2, 25);
    cyc(); req_valid = '0;
    drain("bp_drain");

    // Counter wrap: 65536 handshakes from a fresh reset.
    rst_n = 1'b0;
    cyc(); rst_n = 1'b1;
    sb_bypass = 1'b1;
    set_op(0, 1, 1); req_valid = 4'b0001;
    acc = 0; hs = 0; seen_ffff = 1'b0;
    for (int c = 0; c < 70000 && hs < 65536; c++) begin
      smp();
      if (hs == 65535 && !seen_ffff) begin
        chk("wrap_ffff", 32'(op_cnt), 32'hFFFF);
        seen_ffff = 1'b1;
      end
      if (req_valid[0] && req_ready[0]) acc++;
      if (rsp_valid && rsp_ready) hs++;
      cyc();
      if (acc >= 65536) req_valid = '0;
    end
    chk("wrap_hs_count", 32'(hs), 32'd65536);
    smp();
    chk("wrap_zero", 32'(op_cnt), 32'h0000);
    chk("wrap_idle", 32'(rsp_valid), 32'd0);
    sb_bypass = 1'b0;

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
